// File: rtl/disp_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// disp_cmd_ctrl
//
// Read controller for the external byte-wide command FIFO of the ice40 VGA
// device. It runs the active-low read-strobe handshake against the FIFO's
// active-low empty flag and assembles the bytes into two-byte register-write
// commands. Each command then appears as a single-cycle reg_wr strobe towards
// the display datapath.
//
// Byte protocol: bit7=1 is an address byte and bit7=0 is a data byte. In both
// cases bits[6:0] carry the payload. An address followed by a data byte
// produces one register write.
//
// Parameters:
//   RD_PULSE    clocks the read strobe is held low (1..15)
//   RD_RECOVER  clocks the strobe is held high after a read before the next
//               empty-flag decision (3..15, covers the 2-flop synchronizer)
//
// Ports:
//   clk          global system clock
//   nrst         asynchronous active-low reset
//   nef_in       FIFO empty flag, active-low, asynchronous to clk
//   disp_cmd_in  FIFO data byte
//   disp_cmd_rd  FIFO read strobe, active-low, registered
//   pause        high = do not start new reads (a read in progress completes)
//   busy         high while a read cycle (strobe or recovery) is in progress
//   reg_wr       one-cycle register-write strobe
//   reg_addr     register address, valid with reg_wr, held afterward
//   reg_data     register data, valid with reg_wr, held afterward
//   err_cnt      saturating protocol-error count
//
// Build option:
//   DISP_CMD_ERRCNT_EN  defined: the 8-bit saturating error counter is built.
//                       undefined: err_cnt is tied to 8'h00.
// -----------------------------------------------------------------------------
module disp_cmd_ctrl #(
  parameter int unsigned RD_PULSE   = 4,
  parameter int unsigned RD_RECOVER = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       nef_in,
  input  logic [7:0] disp_cmd_in,
  output logic       disp_cmd_rd,
  input  logic       pause,
  output logic       busy,
  output logic       reg_wr,
  output logic [6:0] reg_addr,
  output logic [6:0] reg_data,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STROBE  = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam logic PH_ADDR = 1'b0;
  localparam logic PH_DATA = 1'b1;

  localparam logic [3:0] PULSE_LD   = 4'(RD_PULSE);
  localparam logic [3:0] RECOVER_LD = 4'(RD_RECOVER);

  logic       nef_m;
  logic       nef_s;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [7:0] byte_q;
  logic       byte_vld;
  logic       phase;
  logic [6:0] pend_addr;

  // Empty-flag synchronizer. It resets to 0, so the FIFO looks empty until
  // two clocks after reset is released.
  // NOTE: every clocked block uses non-blocking assignments, so all flops
  // update together. Blocking assignments here would make nef_s copy the new
  // nef_m in the same edge and merge the two stages into one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nef_m <= 1'b0;
      nef_s <= 1'b0;
    end else begin
      nef_m <= nef_in;
      nef_s <= nef_m;
    end
  end

  // Read handshake FSM. The counter loads on state entry and counts down to 1,
  // so STROBE lasts RD_PULSE clocks and RECOVER lasts RD_RECOVER clocks.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      disp_cmd_rd <= 1'b1;
      busy        <= 1'b0;
      byte_q      <= 8'h00;
      byte_vld    <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (nef_s && !pause) begin
            state       <= ST_STROBE;
            cnt         <= PULSE_LD;
            disp_cmd_rd <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == 4'd1) begin
            state       <= ST_RECOVER;
            cnt         <= RECOVER_LD;
            disp_cmd_rd <= 1'b1;
            // NOTE: disp_cmd_in is not synchronized. It is captured only on the
            // edge that ends the strobe. By then the FIFO output has been driven
            // and stable for the whole pulse.
            byte_q      <= disp_cmd_in;
            byte_vld    <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RECOVER: begin
          if (cnt == 4'd1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          disp_cmd_rd <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Command decoder. It acts one clock after the capture edge. An address byte
  // that arrives in the DATA phase replaces the pending address (resync), so
  // the next data byte pairs with the newest address.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase     <= PH_ADDR;
      pend_addr <= 7'd0;
      reg_wr    <= 1'b0;
      reg_addr  <= 7'd0;
      reg_data  <= 7'd0;
    end else begin
      reg_wr <= 1'b0;
      if (byte_vld) begin
        if (phase == PH_ADDR) begin
          if (byte_q[7]) begin
            pend_addr <= byte_q[6:0];
            phase     <= PH_DATA;
          end
        end else begin
          if (byte_q[7]) begin
            pend_addr <= byte_q[6:0];
          end else begin
            reg_addr <= pend_addr;
            reg_data <= byte_q[6:0];
            reg_wr   <= 1'b1;
            phase    <= PH_ADDR;
          end
        end
      end
    end
  end

`ifdef DISP_CMD_ERRCNT_EN
  // A protocol error is a data byte in the ADDR phase or an address byte in
  // the DATA phase.
  logic       dec_err;
  logic [7:0] err_q;

  assign dec_err = byte_vld && ((phase == PH_ADDR) ? !byte_q[7] : byte_q[7]);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 8'h00;
    end else if (dec_err && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_disp_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_cmd_ctrl
//
// Bench for disp_cmd_ctrl. A queue models the command FIFO. A byte-level
// protocol model predicts the register writes and the error count. A negedge
// monitor checks the strobe length, the busy length and the write timing, and
// compares each write against the prediction.
// -----------------------------------------------------------------------------
module tb_disp_cmd_ctrl;

  localparam int P = 4;
  localparam int R = 3;

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         n;
    int         nwr;
    logic [6:0] a;
    logic [6:0] d;
    int         errd;
  } vec_t;

  logic       clk;
  logic       nrst;
  logic       nef_in;
  logic [7:0] disp_cmd_in;
  logic       disp_cmd_rd;
  logic       pause;
  logic       busy;
  logic       reg_wr;
  logic [6:0] reg_addr;
  logic [6:0] reg_data;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] q[$];
  wr_t        exp_q[$];
  int         falls[$];
  logic       m_data;
  logic [6:0] m_pend;
  int         m_err_raw;
  logic       mon_en;
  int         wr_seen = 0;

  disp_cmd_ctrl #(.RD_PULSE(P), .RD_RECOVER(R)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .nef_in      (nef_in),
    .disp_cmd_in (disp_cmd_in),
    .disp_cmd_rd (disp_cmd_rd),
    .pause       (pause),
    .busy        (busy),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_err();
`ifdef DISP_CMD_ERRCNT_EN
    return (m_err_raw > 255) ? 255 : m_err_raw;
`else
    return 0;
`endif
  endfunction

  // Protocol rules, applied in FIFO order as each byte is queued.
  function automatic void model_byte(input logic [7:0] b);
    if (!m_data) begin
      if (b[7]) begin
        m_pend = b[6:0];
        m_data = 1'b1;
      end else begin
        m_err_raw++;
      end
    end else if (!b[7]) begin
      exp_q.push_back('{a: m_pend, d: b[6:0]});
      m_data = 1'b0;
    end else begin
      m_pend = b[6:0];
      m_err_raw++;
    end
  endfunction

  task automatic push_raw(input logic [7:0] b);
    q.push_back(b);
    nef_in      = 1'b1;
    disp_cmd_in = q[0];
  endtask

  task automatic push(input logic [7:0] b);
    model_byte(b);
    push_raw(b);
  endtask

  // FIFO: a completed strobe (rising edge of the read strobe outside reset)
  // pops the head byte. The DUT captures the byte on the edge that ends the
  // strobe, before this pop takes effect.
  logic prev_rd_f = 1'b1;
  always @(posedge clk) begin
    #1;
    if (nrst && !prev_rd_f && disp_cmd_rd && q.size() > 0) begin
      void'(q.pop_front());
      nef_in      = (q.size() != 0);
      disp_cmd_in = (q.size() != 0) ? q[0] : 8'hA5;
    end
    prev_rd_f = disp_cmd_rd;
  end

  // Monitor.
  logic prev_rd, prev_busy;
  int   low_cnt, busy_cnt, since_rise;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_rd    = 1'b1;
      prev_busy  = 1'b0;
      low_cnt    = 0;
      busy_cnt   = 0;
      since_rise = 99;
    end else begin
      if (since_rise < 99) since_rise++;
      if (!disp_cmd_rd) begin
        if (prev_rd) begin
          falls.push_back(cyc);
          check("busy_at_strobe", busy, 1);
        end
        low_cnt++;
      end else if (!prev_rd) begin
        check("strobe_len", low_cnt, P);
        low_cnt    = 0;
        since_rise = 0;
      end
      if (busy) busy_cnt++;
      else if (prev_busy) begin
        check("busy_len", busy_cnt, P + R);
        busy_cnt = 0;
      end
      if (reg_wr) begin
        wr_seen++;
        check("wr_timing", since_rise, 1);
        check("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", reg_addr, e.a);
          check("wr_data", reg_data, e.d);
        end
      end
      prev_rd   = disp_cmd_rd;
      prev_busy = busy;
    end
  end

  task automatic wait_idle(input int limit);
    int run = 0;
    int t   = 0;
    while (run < 6 && t < limit) begin
      @(negedge clk);
      t++;
      if (q.size() == 0 && !busy) run++;
      else run = 0;
    end
    check("idle_timeout", run >= 6, 1);
  endtask

  task automatic wait_fall(input int n, input int limit);
    int t = 0;
    while (falls.size() < n && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("strobe_timeout", falls.size() >= n, 1);
  endtask

  vec_t vecs[5];

  initial begin
    int c0, e0, w0, lows;

    vecs[0] = '{b0: 8'h10, b1: 8'h81, b2: 8'h7F, n: 3, nwr: 1, a: 7'h01, d: 7'h7F, errd: 1};
    vecs[1] = '{b0: 8'h83, b1: 8'h84, b2: 8'h11, n: 3, nwr: 1, a: 7'h04, d: 7'h11, errd: 1};
    vecs[2] = '{b0: 8'h80, b1: 8'h00, b2: 8'h00, n: 3, nwr: 1, a: 7'h00, d: 7'h00, errd: 1};
    vecs[3] = '{b0: 8'hFF, b1: 8'h7F, b2: 8'h00, n: 2, nwr: 1, a: 7'h7F, d: 7'h7F, errd: 0};
    vecs[4] = '{b0: 8'h81, b1: 8'h82, b2: 8'h33, n: 3, nwr: 1, a: 7'h02, d: 7'h33, errd: 1};

    nrst = 1'b0; nef_in = 1'b0; pause = 1'b0; disp_cmd_in = 8'hA5; mon_en = 1'b0;
    m_data = 1'b0; m_pend = 7'd0; m_err_raw = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rd", disp_cmd_rd, 1);
    check("rst_busy", busy, 0);
    check("rst_wr", reg_wr, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_data", reg_data, 0);
    check("rst_err", err_cnt, 0);
    nrst = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_rd", disp_cmd_rd, 1);

    // Basic two-byte command: latency, strobe gap, single write.
    falls.delete();
    c0 = cyc;
    w0 = wr_seen;
    push(8'h85);
    push(8'h2A);
    wait_fall(2, 100);
    if (falls.size() >= 2) begin
      check("first_latency", falls[0] - c0, 3);
      check("strobe_gap", falls[1] - falls[0], P + R + 1);
    end
    wait_idle(200);
    check("basic_nwr", wr_seen - w0, 1);
    check("basic_addr_held", reg_addr, 7'h05);
    check("basic_data_held", reg_data, 7'h2A);

    // Table-driven command sequences.
    for (int i = 0; i < 5; i++) begin
      e0 = err_cnt;
      w0 = wr_seen;
      push(vecs[i].b0);
      if (vecs[i].n > 1) push(vecs[i].b1);
      if (vecs[i].n > 2) push(vecs[i].b2);
      wait_idle(300);
      check($sformatf("vec%0d_nwr", i), wr_seen - w0, vecs[i].nwr);
      check($sformatf("vec%0d_addr", i), reg_addr, vecs[i].a);
      check($sformatf("vec%0d_data", i), reg_data, vecs[i].d);
`ifdef DISP_CMD_ERRCNT_EN
      check($sformatf("vec%0d_errd", i), err_cnt - e0, vecs[i].errd);
`else
      check($sformatf("vec%0d_errd", i), err_cnt - e0, 0);
`endif
    end
    check("table_err", err_cnt, exp_err());

    // pause holds off reads. Release starts a read on the next edge, and a
    // pause raised mid-strobe does not shorten the strobe.
    @(negedge clk);
    pause = 1'b1;
    falls.delete();
    push(8'h81);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!disp_cmd_rd || busy) lows++;
    end
    check("pause_block", lows, 0);
    pause = 1'b0;
    c0 = cyc;
    wait_fall(1, 20);
    if (falls.size() >= 1) check("pause_release", falls[0] - c0, 1);
    @(negedge clk);
    pause = 1'b1;
    lows = 0;
    while (busy && lows < 50) begin
      @(negedge clk);
      lows++;
    end
    check("pause_read_done", busy, 0);
    push(8'h22);
    repeat (20) @(negedge clk);
    check("pause_no_second", falls.size(), 1);
    pause = 1'b0;
    wait_idle(200);
    check("pause_addr", reg_addr, 7'h01);
    check("pause_data", reg_data, 7'h22);

    // Reset two clocks into a strobe, with the decoder in the DATA phase.
    push(8'h86);
    wait_idle(200);
    mon_en = 1'b0;
    push_raw(8'h87);
    lows = 0;
    while (disp_cmd_rd && lows < 50) begin
      @(negedge clk);
      lows++;
    end
    check("abort_strobe_seen", disp_cmd_rd, 0);
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("abort_rd", disp_cmd_rd, 1);
    check("abort_busy", busy, 0);
    check("abort_wr", reg_wr, 0);
    check("abort_addr", reg_addr, 0);
    check("abort_data", reg_data, 0);
    check("abort_err", err_cnt, 0);
    q.delete();
    nef_in = 1'b0;
    disp_cmd_in = 8'hA5;
    m_data = 1'b0; m_pend = 7'd0; m_err_raw = 0;
    exp_q.delete();
    push(8'h11);
    repeat (2) @(negedge clk);
    w0 = wr_seen;
    falls.delete();
    nrst = 1'b1;
    c0 = cyc;
    mon_en = 1'b1;
    wait_fall(1, 20);
    if (falls.size() >= 1) check("post_rst_latency", falls[0] - c0, 3);
    wait_idle(200);
    check("post_rst_nwr", wr_seen - w0, 0);
    check("post_rst_err", err_cnt, exp_err());

    // Random byte stream with random gaps and pause, against the model.
    for (int i = 0; i < 60; i++) begin
      pause = ($urandom_range(0, 5) == 0);
      push(8'($urandom));
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    pause = 1'b0;
    wait_idle(3000);
    check("rand_err", err_cnt, exp_err());
    check("rand_pending_wr", exp_q.size(), 0);

    // Saturation: 300 bad bytes.
    for (int i = 0; i < 300; i++) push(8'h00);
    wait_idle(5000);
    check("sat_err", err_cnt, exp_err());
    check("final_pending_wr", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
